// File: rtl/hack_arb4_way16.sv
// hack_arb4_way16: four-requester round-robin arbiter feeding a one-word
// output register with valid/ready handshake and a transfer counter.
// ack is combinational in the capture cycle. The granted word lands on out
// one cycle later.
module hack_arb4_way16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       ack,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [15:0]      xfer_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [15:0]      cnt_q;

  logic             cap_s;
  logic             found_s;
  logic [1:0]       win_s;
  logic [1:0]       idx_s;
  logic [WIDTH-1:0] win_data_s;

  // The output slot can take a word when empty or when it drains this cycle.
  // Reset suppresses capture so that no ack is issued while reset is high.
  assign cap_s = ((state_q == EMPTY) | out_ready) & ~reset;

  // Round-robin search starting at ptr: first requesting index wins.
  always_comb begin
    found_s = 1'b0;
    win_s   = 2'd0;
    idx_s   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx_s = ptr_q + k[1:0];
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // 4-way data mux driven by the winner index (never feeds back into ack).
  always_comb begin
    win_data_s = a;
    case (win_s)
      2'd0:    win_data_s = a;
      2'd1:    win_data_s = b;
      2'd2:    win_data_s = c;
      2'd3:    win_data_s = d;
      default: win_data_s = a;
    endcase
  end

  // Next-state logic and the one-hot ack for the EMPTY/FULL slot FSM.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    ack     = 4'b0000;
    if (cap_s) begin
      if (found_s) begin
        ack[win_s] = 1'b1;
        out_d      = win_data_s;
        sel_d      = win_s;
        ptr_d      = win_s + 2'd1;
        state_d    = FULL;
      end else begin
        state_d = EMPTY;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, data, pointer and transfer-count registers; reset wins over all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      out_q   <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      if ((state_q == FULL) && out_ready) begin
        cnt_q <= cnt_q + 16'd1;
      end else begin
        cnt_q <= cnt_q;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == FULL);
  assign sel       = sel_q;
  assign xfer_cnt  = cnt_q;

endmodule
